// File: rtl/alu_cmd_driver_pkg.sv
// Shared definitions for the ALU command driver: opcode values, legality limit
// and the sequencer state encoding.
package alu_pkg;

  localparam logic [3:0] OP_ADD   = 4'd0;
  localparam logic [3:0] OP_SUB   = 4'd1;
  localparam logic [3:0] OP_SHIFT = 4'd2;
  localparam logic [3:0] OP_CMP   = 4'd3;
  localparam logic [3:0] OP_EXOR  = 4'd4;
  localparam logic [3:0] OP_BCMP  = 4'd5;
  localparam logic [3:0] OP_AND   = 4'd6;
  localparam logic [3:0] OP_NAND  = 4'd7;
  localparam logic [3:0] OP_OR    = 4'd8;
  localparam logic [3:0] OP_NOR   = 4'd9;
  localparam logic [3:0] OP_LAST  = OP_NOR;

  // Upper opcode bits presented to the CPU are always zero.
  localparam int OP_PAD_W = 3;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD_A = 3'd1,
    ST_EXEC   = 3'd2,
    ST_WAIT   = 3'd3,
    ST_RESP   = 3'd4
  } state_t;

  function automatic logic op_legal(input logic [3:0] op);
    return op <= OP_LAST;
  endfunction

endpackage

// File: rtl/alu_cmd_driver.sv
// Sequences one ALU command onto the CPU operand pins (load A, execute with B),
// waits a fixed latency, captures the result and hands it back via valid/ready.
module alu_cmd_driver
  import alu_pkg::*;
#(
  parameter int RESP_LAT = 1,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [3:0]       cmd_op,
  input  logic [7:0]       cmd_a,
  input  logic [7:0]       cmd_b,
  input  logic             cmd_cin,
  output logic [7:0]       data_in,
  output logic [6:0]       opcode,
  output logic             cin,
  output logic             load,
  output logic             ce,
  input  logic [7:0]       data_out,
  input  logic             cout,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [7:0]       res_data,
  output logic             res_cout,
  output logic             res_err,
  output logic [CNT_W-1:0] issue_cnt
);

  state_t     state, state_nxt;
  logic [3:0] wait_cnt;
  logic [7:0] b_lat;
  logic       cin_lat;
  logic       accept;

  logic [7:0] data_in_nxt;
  logic [6:0] opcode_nxt;
  logic       cin_nxt, load_nxt, ce_nxt, cmd_ready_nxt, res_valid_nxt;
  logic [7:0] res_data_nxt;
  logic       res_cout_nxt, res_err_nxt;

  // cmd_ready is held low for the first cycle after reset, so it gates acceptance.
  assign accept = cmd_ready & cmd_valid;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (accept) state_nxt = op_legal(cmd_op) ? ST_LOAD_A : ST_RESP;
      ST_LOAD_A: state_nxt = ST_EXEC;
      ST_EXEC:   state_nxt = ST_WAIT;
      ST_WAIT:   if (wait_cnt == 4'd0) state_nxt = ST_RESP;
      ST_RESP:   if (res_ready) state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // Outputs are decoded from the next state and registered.
  always_comb begin
    load_nxt      = (state_nxt == ST_LOAD_A);
    ce_nxt        = (state_nxt == ST_EXEC);
    cmd_ready_nxt = (state_nxt == ST_IDLE);
    res_valid_nxt = (state_nxt == ST_RESP);
    cin_nxt       = (state_nxt == ST_EXEC) ? cin_lat : 1'b0;
    data_in_nxt   = 8'd0;
    opcode_nxt    = opcode;
    res_data_nxt  = res_data;
    res_cout_nxt  = res_cout;
    res_err_nxt   = res_err;
    case (state_nxt)
      ST_IDLE:   opcode_nxt = 7'd0;
      ST_LOAD_A: begin
        data_in_nxt = cmd_a;
        opcode_nxt  = {{OP_PAD_W{1'b0}}, cmd_op};
      end
      ST_EXEC:   data_in_nxt = b_lat;
      default:   ;
    endcase
    if (state == ST_WAIT && state_nxt == ST_RESP) begin
      res_data_nxt = data_out;
      res_cout_nxt = cout;
      res_err_nxt  = 1'b0;
    end else if (state == ST_IDLE && state_nxt == ST_RESP) begin
      res_data_nxt = 8'd0;
      res_cout_nxt = 1'b0;
      res_err_nxt  = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cmd_ready <= 1'b0;
      data_in   <= 8'd0;
      opcode    <= 7'd0;
      cin       <= 1'b0;
      load      <= 1'b0;
      ce        <= 1'b0;
      res_valid <= 1'b0;
      res_data  <= 8'd0;
      res_cout  <= 1'b0;
      res_err   <= 1'b0;
    end else begin
      cmd_ready <= cmd_ready_nxt;
      data_in   <= data_in_nxt;
      opcode    <= opcode_nxt;
      cin       <= cin_nxt;
      load      <= load_nxt;
      ce        <= ce_nxt;
      res_valid <= res_valid_nxt;
      res_data  <= res_data_nxt;
      res_cout  <= res_cout_nxt;
      res_err   <= res_err_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wait_cnt  <= 4'd0;
      issue_cnt <= '0;
    end else begin
      if (state == ST_EXEC) begin
        wait_cnt  <= 4'(RESP_LAT - 1);
        issue_cnt <= issue_cnt + CNT_W'(1);
      end else if (state == ST_WAIT) begin
        wait_cnt  <= wait_cnt - 4'd1;
      end
    end
  end

  // Operand B and carry are only needed two cycles later; no reset required.
  always_ff @(posedge clk) begin
    if (accept) begin
      b_lat   <= cmd_b;
      cin_lat <= cmd_cin;
    end
  end

endmodule

// File: tb/tb_alu_cmd_driver.sv
// Bench for alu_cmd_driver: a behavioural CPU model plus per-command expected
// pin/result sequence derived from the command fields.
module tb_alu_cmd_driver;

  localparam int RESP_LAT = 3;
  localparam int CNT_W    = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             cmd_valid = 1'b0;
  logic             cmd_ready;
  logic [3:0]       cmd_op = 4'd0;
  logic [7:0]       cmd_a = 8'd0;
  logic [7:0]       cmd_b = 8'd0;
  logic             cmd_cin = 1'b0;
  logic [7:0]       data_in;
  logic [6:0]       opcode;
  logic             cin;
  logic             load;
  logic             ce;
  logic [7:0]       data_out;
  logic             cout;
  logic             res_valid;
  logic             res_ready = 1'b0;
  logic [7:0]       res_data;
  logic             res_cout;
  logic             res_err;
  logic [CNT_W-1:0] issue_cnt;

  int         errors = 0;
  int         checks = 0;
  logic [3:0] exp_cnt = 4'd0;

  alu_cmd_driver #(.RESP_LAT(RESP_LAT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_cin(cmd_cin),
    .data_in(data_in), .opcode(opcode), .cin(cin), .load(load), .ce(ce),
    .data_out(data_out), .cout(cout),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_cout(res_cout), .res_err(res_err), .issue_cnt(issue_cnt)
  );

  always #5 clk = ~clk;

  // Returns {carry, result} for the ALU operation.
  function automatic logic [8:0] alu_ref(input logic [3:0] op, input logic [7:0] a,
                                         input logic [7:0] b, input logic c);
    case (op)
      4'd0:    return {1'b0, a} + {1'b0, b} + {8'd0, c};
      4'd1:    return {1'b0, a} - {1'b0, b} - {8'd0, c};
      4'd2:    return {a, c};
      4'd3:    return {a < b, (a == b) ? 8'h01 : 8'h00};
      4'd4:    return {1'b0, a ^ b};
      4'd5:    return {a == b, ~(a ^ b)};
      4'd6:    return {1'b0, a & b};
      4'd7:    return {1'b0, ~(a & b)};
      4'd8:    return {1'b0, a | b};
      4'd9:    return {1'b0, ~(a | b)};
      default: return 9'd0;
    endcase
  endfunction

  // CPU model: result is valid for exactly RESP_LAT cycles after the execute edge.
  logic [7:0] cpu_a;
  int         cpu_hold;
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      cpu_a <= 8'd0; data_out <= 8'd0; cout <= 1'b0; cpu_hold <= 0;
    end else begin
      if (load) cpu_a <= data_in;
      if (ce) begin
        {cout, data_out} <= alu_ref(opcode[3:0], cpu_a, data_in, cin);
        cpu_hold <= RESP_LAT;
      end else if (cpu_hold > 0) begin
        cpu_hold <= cpu_hold - 1;
        if (cpu_hold == 1) begin
          data_out <= 8'($urandom);
          cout     <= 1'($urandom);
        end
      end
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic scramble_cmd();
    cmd_op  = 4'($urandom);
    cmd_a   = 8'($urandom);
    cmd_b   = 8'($urandom);
    cmd_cin = 1'($urandom);
  endtask

  // Called at a negedge with the driver idle; returns at a negedge, idle again.
  task automatic run_cmd(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                         input logic c, input int hold);
    logic [8:0] exp_r;
    exp_r = alu_ref(op, a, b, c);
    check_eq("ready_idle", 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1; cmd_op = op; cmd_a = a; cmd_b = b; cmd_cin = c;
    res_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    scramble_cmd();
    if (op <= 4'd9) begin
      check_eq("load_a_load", 32'(load), 32'd1);
      check_eq("load_a_ce", 32'(ce), 32'd0);
      check_eq("load_a_data", 32'(data_in), 32'(a));
      check_eq("load_a_opcode", 32'(opcode), 32'(op));
      check_eq("load_a_ready", 32'(cmd_ready), 32'd0);
      @(negedge clk);
      check_eq("exec_ce", 32'(ce), 32'd1);
      check_eq("exec_load", 32'(load), 32'd0);
      check_eq("exec_data", 32'(data_in), 32'(b));
      check_eq("exec_opcode", 32'(opcode), 32'(op));
      check_eq("exec_cin", 32'(cin), 32'(c));
      exp_cnt = exp_cnt + 4'd1;
      for (int i = 0; i < RESP_LAT; i++) begin
        @(negedge clk);
        check_eq("wait_ctl", 32'({load, ce, res_valid}), 32'd0);
        check_eq("wait_data", 32'(data_in), 32'd0);
        check_eq("wait_opcode", 32'(opcode), 32'(op));
        check_eq("wait_cnt", 32'(issue_cnt), 32'(exp_cnt));
      end
      @(negedge clk);
      check_eq("resp_valid", 32'(res_valid), 32'd1);
      check_eq("resp_data", 32'(res_data), 32'(exp_r[7:0]));
      check_eq("resp_cout", 32'(res_cout), 32'(exp_r[8]));
      check_eq("resp_err", 32'(res_err), 32'd0);
    end else begin
      check_eq("rej_valid", 32'(res_valid), 32'd1);
      check_eq("rej_err", 32'(res_err), 32'd1);
      check_eq("rej_data", 32'({res_cout, res_data}), 32'd0);
      check_eq("rej_ctl", 32'({load, ce}), 32'd0);
      check_eq("rej_cnt", 32'(issue_cnt), 32'(exp_cnt));
      exp_r = 9'd0;
    end
    check_eq("resp_ready", 32'(cmd_ready), 32'd0);
    for (int h = 0; h < hold; h++) begin
      scramble_cmd();
      @(negedge clk);
      check_eq("hold_valid", 32'(res_valid), 32'd1);
      check_eq("hold_data", 32'({res_cout, res_data}), 32'(exp_r));
      check_eq("hold_err", 32'(res_err), 32'(op > 4'd9));
      check_eq("hold_ready", 32'(cmd_ready), 32'd0);
      check_eq("hold_ctl", 32'({load, ce}), 32'd0);
    end
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    check_eq("done_valid", 32'(res_valid), 32'd0);
    check_eq("done_ready", 32'(cmd_ready), 32'd1);
  endtask

  task automatic reset_in_exec(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    check_eq("rx_ready", 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1; cmd_op = op; cmd_a = a; cmd_b = b; cmd_cin = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    check_eq("rx_load", 32'(load), 32'd1);
    @(negedge clk);
    check_eq("rx_ce", 32'(ce), 32'd1);
    #2 rst = 1'b0;
    #1;
    check_eq("rx_ctl", 32'({load, ce, cin, res_valid, cmd_ready}), 32'd0);
    check_eq("rx_data", 32'(data_in), 32'd0);
    check_eq("rx_opcode", 32'(opcode), 32'd0);
    check_eq("rx_cnt", 32'(issue_cnt), 32'd0);
    exp_cnt = 4'd0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_eq("rx_ready_back", 32'(cmd_ready), 32'd1);
    check_eq("rx_no_result", 32'(res_valid), 32'd0);
  endtask

  initial begin
    logic [3:0] rop;
    #12;
    check_eq("rst_ready", 32'(cmd_ready), 32'd0);
    check_eq("rst_ctl", 32'({load, ce, cin, res_valid, res_err, res_cout}), 32'd0);
    check_eq("rst_data", 32'({data_in, res_data}), 32'd0);
    check_eq("rst_opcode", 32'(opcode), 32'd0);
    check_eq("rst_cnt", 32'(issue_cnt), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_eq("rel_ready_low", 32'(cmd_ready), 32'd0);
    @(negedge clk);

    run_cmd(4'd0, 8'h05, 8'h03, 1'b0, 0);
    check_eq("add_cnt", 32'(issue_cnt), 32'd1);
    run_cmd(4'd1, 8'h00, 8'h01, 1'b0, 3);
    run_cmd(4'hC, 8'h12, 8'h34, 1'b1, 1);
    check_eq("rej_cnt_after", 32'(issue_cnt), 32'd2);
    reset_in_exec(4'd4, 8'hA5, 8'h5A);
    run_cmd(4'd0, 8'hFF, 8'h01, 1'b1, 0);
    run_cmd(4'd9, 8'h0F, 8'h30, 1'b0, 0);
    run_cmd(4'd8, 8'h0F, 8'h30, 1'b0, 0);
    for (int i = 0; i < 17; i++)
      run_cmd(4'($urandom_range(0, 9)), 8'($urandom), 8'($urandom), 1'($urandom), 0);
    for (int i = 0; i < 25; i++) begin
      rop = 4'($urandom_range(0, 12));
      if (i % 7 == 3) rop = 4'($urandom_range(10, 15));
      run_cmd(rop, 8'($urandom), 8'($urandom), 1'($urandom), int'($urandom_range(0, 2)));
    end
    check_eq("final_cnt", 32'(issue_cnt), 32'(exp_cnt));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
